sr_calc_unit: RTL and testbench
===============================

# sr_calc_unit

Multi-cycle arithmetic responder for the core's custom calculator instruction. It computes y = a³ + b² on 8-bit unsigned operands with one shared shift-add datapath. It answers the core's start/busy handshake: the control unit raises start and stalls the PC, and this block holds busy_o until the 24-bit result is registered. It sits beside the ALU, fed by rs1[7:0] and srcB[7:0], and drives the low 24 bits of the writeback mux.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level request from control; sampled only in IDLE.
- a  input  8  unsigned operand A, captured on accept.
- b  input  8  unsigned operand B, captured on accept.
- y  output  24  result register; holds its value until the next completion.
- busy_o  output  1  high while an operation is in progress.

## Operation
- Registers:
  - opA and opB (8 bit each), latched on accept.
  - p (16 bit), holds the a² partial product.
  - acc (24 bit), the accumulator.
  - bit counter cnt (3 bit).
  - state.
- States are IDLE, SQ_A, CUBE, ADD_B and DONE.
- IDLE: when start=1, latch opA=a, opB=b, clear acc, p and cnt, then go to SQ_A. Otherwise stay.
- SQ_A, one bit per cycle, i=cnt: if opA[i], p += opA<<i. After i=7, go to CUBE with cnt=0.
- CUBE: if opA[i], acc += p<<i. After i=7, go to ADD_B with cnt=0.
- ADD_B: if opB[i], acc += opB<<i. After i=7, load y = acc + last term and go to DONE.
- DONE: lasts one cycle and start is ignored. This gives the core one cycle to advance past the stalled instruction. Go to IDLE.
- busy_o=1 in SQ_A, CUBE and ADD_B; busy_o=0 in IDLE and DONE. busy_o is registered, never decoded combinationally from start.
- Width rules:
  - All arithmetic is unsigned.
  - Maximum result is 255³+255² = 16,646,400 = 0xFE0100 < 2²⁴, so there is no overflow and no truncation.
  - p never exceeds 0xFE01.
- a and b may change freely after accept; only the latched copies are used.
- start is ignored in SQ_A, CUBE, ADD_B and DONE.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, busy_o=0, y=0.
  - acc, p, opA, opB and cnt are all 0.
- Reset asserted mid-operation aborts it. y returns to 0 and no partial result is ever presented.
- Accept at edge k (IDLE, start=1): busy_o=1 after edge k.
- Iterations run on edges k+1 … k+24 (8 per phase).
- At edge k+24: y is updated, busy_o→0 and state=DONE.
- At edge k+25: state=IDLE. The earliest next accept is edge k+26.
- Latency from accept to valid y is 24 cycles. Throughput is one operation per 26 cycles when start is held high.
- The falling edge of busy_o and the new y appear in the same cycle. The consumer may sample y in any cycle where busy_o=0 after that.

## Configuration
- SR_CALC_RADIX4_EN defined:
  - Each phase processes 2 operand bits per cycle (two conditional adds per edge); cnt counts 0..3.
  - busy_o is high for 12 cycles.
  - y updates at edge k+12, DONE at k+12, IDLE at k+13.
- Not defined: the 1-bit/cycle, 24-cycle behaviour above.
- Results are bit-identical in both builds. The DONE-cycle rule and reset behaviour are unchanged.

## Test plan
- Reset then basic operation:
  - After reset, y=0 and busy_o=0.
  - Pulse start with a=3, b=4.
  - busy_o is high exactly 24 cycles (12 with SR_CALC_RADIX4_EN), then y=0x00002B (43).
- Extremes:
  - a=255, b=255 → y=0xFE0100.
  - a=0, b=0 → y=0x000000 with the full busy duration.
  - a=1, b=0 → y=0x000001.
- Operand and start changes during busy:
  - Accept a=2, b=5.
  - During busy, toggle start and change a and b to 0xFF.
  - Result is y=0x000021 (33). There is no restart and busy length is unchanged.
- Held start, back-to-back operations:
  - Hold start=1 continuously with a=10, b=0.
  - Completion gives y=1000 (0x0003E8).
  - One DONE cycle follows with busy_o=0, then a new accept. The second result is also 1000.
- Reset mid-operation:
  - Assert rst 10 cycles after accepting a=7, b=7.
  - Outputs go immediately to busy_o=0 and y=0.
  - After release, a new start with a=7, b=7 gives y=392 (0x000188).
- Random check: 1000 random (a, b) pairs compared against a reference model a³+b², checking both builds.

Source files
------------

// File: rtl/sr_calc_unit.sv
// Multi-cycle y = a^3 + b^2 responder on one shared shift-add datapath.
// Define SR_CALC_RADIX4_EN to retire two operand bits per cycle instead of one.
module sr_calc_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [23:0] y,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, SQ_A, CUBE, ADD_B, DONE} state_t;

`ifdef SR_CALC_RADIX4_EN
  localparam logic [2:0] CNT_LAST = 3'd3;
`else
  localparam logic [2:0] CNT_LAST = 3'd7;
`endif

  state_t      state;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] p;
  logic [23:0] acc;
  logic [2:0]  cnt;

  logic [15:0] p_next;
  logic [23:0] acc_cube_next;
  logic [23:0] acc_b_next;
  logic        last_step;

  // Conditional partial products; every term fits without truncation.
  function automatic logic [15:0] sq_term(input logic [7:0] m, input logic [2:0] i);
    return m[i] ? (16'(m) << i) : 16'd0;
  endfunction

  function automatic logic [23:0] cube_term(input logic [7:0] m, input logic [15:0] pp,
                                            input logic [2:0] i);
    return m[i] ? (24'(pp) << i) : 24'd0;
  endfunction

  function automatic logic [23:0] b_term(input logic [7:0] m, input logic [2:0] i);
    return m[i] ? (24'(m) << i) : 24'd0;
  endfunction

  always_comb begin
    last_step = (cnt == CNT_LAST);
`ifdef SR_CALC_RADIX4_EN
    p_next        = p + sq_term(op_a, {cnt[1:0], 1'b0})
                      + sq_term(op_a, {cnt[1:0], 1'b1});
    acc_cube_next = acc + cube_term(op_a, p, {cnt[1:0], 1'b0})
                        + cube_term(op_a, p, {cnt[1:0], 1'b1});
    acc_b_next    = acc + b_term(op_b, {cnt[1:0], 1'b0})
                        + b_term(op_b, {cnt[1:0], 1'b1});
`else
    p_next        = p + sq_term(op_a, cnt);
    acc_cube_next = acc + cube_term(op_a, p, cnt);
    acc_b_next    = acc + b_term(op_b, cnt);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      y      <= '0;
      acc    <= '0;
      p      <= '0;
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            acc    <= '0;
            p      <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= SQ_A;
          end
        end
        SQ_A: begin
          p <= p_next;
          if (last_step) begin
            cnt   <= '0;
            state <= CUBE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CUBE: begin
          acc <= acc_cube_next;
          if (last_step) begin
            cnt   <= '0;
            state <= ADD_B;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ADD_B: begin
          acc <= acc_b_next;
          if (last_step) begin
            // Result and busy drop land together so the core sees a clean handoff.
            y      <= acc_b_next;
            busy_o <= 1'b0;
            cnt    <= '0;
            state  <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_calc_unit.sv
// Directed and random checks of sr_calc_unit: result values, busy length and handshake.
module tb_sr_calc_unit;

`ifdef SR_CALC_RADIX4_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 24;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [23:0] y;
  logic        busy_o;

  int tests;
  int errors;

  sr_calc_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .y      (y),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Counts busy cycles starting from the sample just after the current edge.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [23:0] expy, input string tag);
    int n;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    count_busy(n);
    check({tag, "_busy"}, n, LAT);
    check({tag, "_y"}, y, expy);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int ai, bi;
    tests = 0; errors = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    check("rst_y", y, 0);
    check("rst_busy", busy_o, 0);
    @(negedge clk); rst = 1'b0;

    do_op(8'd3,   8'd4,   24'h00002B, "basic");
    do_op(8'd255, 8'd255, 24'hFE0100, "max");
    do_op(8'd0,   8'd0,   24'h000000, "zero");
    do_op(8'd1,   8'd0,   24'h000001, "one");

    // Operands and start wiggle during busy without effect.
    @(negedge clk);
    a = 8'd2; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; start = ~start;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("wiggle_busy", n, LAT);
    check("wiggle_y", y, 24'h000021);
    @(posedge clk); #1;
    check("wiggle_idle", busy_o, 0);
    @(posedge clk); #1;

    // Held start: DONE cycle then immediate re-accept.
    @(negedge clk);
    a = 8'd10; b = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    count_busy(n);
    check("held1_busy", n, LAT);
    check("held1_y", y, 24'h0003E8);
    @(posedge clk); #1;
    check("held_done_busy", busy_o, 0);
    @(posedge clk); #1;
    count_busy(n);
    check("held2_busy", n, LAT);
    check("held2_y", y, 24'h0003E8);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset aborts an operation in flight.
    @(negedge clk);
    a = 8'd7; b = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_y", y, 0);
    @(negedge clk); rst = 1'b0;
    do_op(8'd7, 8'd7, 24'h000188, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      ai = int'($urandom_range(0, 255));
      bi = int'($urandom_range(0, 255));
      do_op(8'(ai), 8'(bi), 24'(ai * ai * ai + bi * bi), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
